// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the platform interrupt arbiter.
package cv32e40p_pkg;

    typedef enum logic [0:0] {
        IRQ_ARB_IDLE = 1'b0,
        IRQ_ARB_BUSY = 1'b1
    } irq_arb_state_e;

    localparam int unsigned IRQ_ARB_ID_NONE = 0;

endpackage

// File: rtl/cv32e40p_irq_gateway.sv
// Per-source interrupt gateway: edge/level capture, pending latch and in-service flag.
module cv32e40p_irq_gateway
    import cv32e40p_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic src_i,
    input  logic edge_mode_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o,
    output logic in_service_o
);

    logic src_q, src_d;
    logic pending_q, pending_d;
    logic in_service_q, in_service_d;
    logic set;

    always_comb begin
        src_d = src_i;
        // A level source entering service on this edge must not re-pend from
        // the same high level; edges are never masked by service.
        if (edge_mode_i) begin
            set = src_i & ~src_q;
        end else begin
            set = src_i & ~(in_service_q | claim_i);
        end
        pending_d = set | (pending_q & ~claim_i);
        in_service_d = in_service_q;
        if (claim_i) begin
            in_service_d = 1'b1;
        end else if (complete_i) begin
            in_service_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q        <= 1'b0;
            pending_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            src_q        <= src_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
        end
    end

    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;

endmodule

// File: rtl/cv32e40p_irq_arbiter.sv
// Prioritising interrupt arbiter feeding the core MEI line, with a
// single-outstanding claim/complete handshake.
module cv32e40p_irq_arbiter
    import cv32e40p_pkg::*;
#(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned PRIO_W  = 3,
    parameter int unsigned ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_i,
    input  logic [NUM_SRC-1:0]        edge_mode_i,
    input  logic [NUM_SRC-1:0]        enable_i,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
    input  logic [PRIO_W-1:0]         threshold_i,
    output logic                      irq_o,
    input  logic                      claim_i,
    output logic                      claim_rsp_o,
    output logic [ID_W-1:0]           claim_id_o,
    input  logic                      complete_i,
    input  logic [ID_W-1:0]           complete_id_i,
    output logic [NUM_SRC-1:0]        pending_o
);

    localparam logic [ID_W-1:0] ID_NONE = ID_W'(IRQ_ARB_ID_NONE);

    irq_arb_state_e state_q, state_d;
    logic [ID_W-1:0] active_id_q, active_id_d;
    logic [ID_W-1:0] best_id_q, best_id_d;
    logic            best_valid_q, best_valid_d;
    logic            claim_rsp_q, claim_rsp_d;
    logic [ID_W-1:0] claim_id_q, claim_id_d;
    logic            claim_go, complete_go;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] gw_claim;
    logic [NUM_SRC-1:0] gw_complete;
    logic [PRIO_W-1:0]  prio_arr [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign prio_arr[gi]    = prio_i[gi*PRIO_W +: PRIO_W];
            assign eligible[gi]    = pending[gi] & enable_i[gi] & (prio_arr[gi] > threshold_i);
            assign gw_claim[gi]    = claim_go & (best_id_q == ID_W'(gi + 1));
            assign gw_complete[gi] = complete_go & (active_id_q == ID_W'(gi + 1));

            cv32e40p_irq_gateway u_gateway (
                .clk          (clk),
                .rst          (rst),
                .src_i        (src_i[gi]),
                .edge_mode_i  (edge_mode_i[gi]),
                .claim_i      (gw_claim[gi]),
                .complete_i   (gw_complete[gi]),
                .pending_o    (pending[gi]),
                .in_service_o (in_service[gi])
            );
        end
    endgenerate

    // Strict '>' while scanning upward keeps the lowest index on priority ties.
    always_comb begin
        logic [PRIO_W-1:0] best_prio;
        best_prio    = '0;
        best_valid_d = 1'b0;
        best_id_d    = ID_NONE;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (eligible[k] && (!best_valid_d || (prio_arr[k] > best_prio))) begin
                best_valid_d = 1'b1;
                best_prio    = prio_arr[k];
                best_id_d    = ID_W'(k + 1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        claim_rsp_d = 1'b0;
        claim_id_d  = ID_NONE;
        claim_go    = 1'b0;
        complete_go = 1'b0;
        irq_o       = 1'b0;
        case (state_q)
            IRQ_ARB_IDLE: begin
                irq_o = best_valid_q;
                if (claim_i) begin
                    claim_rsp_d = 1'b1;
                    if (best_valid_q) begin
                        claim_go    = 1'b1;
                        claim_id_d  = best_id_q;
                        active_id_d = best_id_q;
                        state_d     = IRQ_ARB_BUSY;
                    end
                end
            end
            IRQ_ARB_BUSY: begin
                if (claim_i) begin
                    claim_rsp_d = 1'b1;
                end
                if (complete_i && (complete_id_i == active_id_q)) begin
                    complete_go = 1'b1;
                    active_id_d = ID_NONE;
                    state_d     = IRQ_ARB_IDLE;
                end
            end
            default: state_d = IRQ_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IRQ_ARB_IDLE;
            active_id_q  <= ID_NONE;
            best_valid_q <= 1'b0;
            best_id_q    <= ID_NONE;
            claim_rsp_q  <= 1'b0;
            claim_id_q   <= ID_NONE;
        end else begin
            state_q      <= state_d;
            active_id_q  <= active_id_d;
            best_valid_q <= best_valid_d;
            best_id_q    <= best_id_d;
            claim_rsp_q  <= claim_rsp_d;
            claim_id_q   <= claim_id_d;
        end
    end

    assign claim_rsp_o = claim_rsp_q;
    assign claim_id_o  = claim_id_q;
    assign pending_o   = pending;

endmodule
